// File: rtl/fc_sched_pkg.sv
// Shared constants and width helpers for the FC neuron scheduler.
package fc_sched_pkg;

    // Scheduler states
    localparam int unsigned STATE_W   = 2;
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_LOAD   = 2'd1;
    localparam logic [1:0]  ST_SETTLE = 2'd2;
    localparam logic [1:0]  ST_EMIT   = 2'd3;

    // Datapath result width: full product width plus adder-tree growth
    function automatic int unsigned zw(input int unsigned width, input int unsigned n);
        return width * 2 + $clog2(n);
    endfunction

    // Counter width for a range of n values, never narrower than one bit
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_input_buffer.sv
// Addressed register array holding one activation vector for the FC datapath.
module fc_input_buffer
    import fc_sched_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned IN    = 128,
    localparam int unsigned PW    = cw(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [PW-1:0]    wr_ptr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] x_buf_o [0:IN-1]
);

    // One entry written per accepted activation; whole array cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(IN); i++) begin
                x_buf_o[i] <= '0;
            end
        end else if (wr_en_i) begin
            x_buf_o[wr_ptr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fc_neuron_scheduler.sv
// Time-multiplexes one combinational FC neuron datapath across N_OUT neurons:
// serial vector load, per-neuron settle window, registered result stream.
// Optional build macro FC_ARGMAX_EN adds argmax_valid/argmax_idx outputs.
module fc_neuron_scheduler
    import fc_sched_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned IN         = 128,
    parameter  int unsigned N_OUT      = 10,
    parameter  int unsigned SETTLE_CYC = 2,
    localparam int unsigned ZW         = zw(WIDTH, IN),
    localparam int unsigned SW         = cw(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] x_buf [0:IN-1],
    output logic [SW-1:0]    sel,
    input  logic [ZW-1:0]    z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    out_data,
    output logic [SW-1:0]    out_idx,
    output logic             out_last,
`ifdef FC_ARGMAX_EN
    output logic             argmax_valid,
    output logic [SW-1:0]    argmax_idx,
`endif
    output logic             busy
);

    localparam int unsigned PW = cw(IN);
    localparam int unsigned CW = cw(SETTLE_CYC);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [CW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [ZW-1:0]      out_data_q, out_data_d;
    logic [SW-1:0]      out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               in_fire_c;
    logic               out_fire_c;

    assign in_fire_c  = in_valid && in_ready_q;
    assign out_fire_c = out_valid_q && out_ready;

    // Activation storage, addressed by the load pointer
    fc_input_buffer #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) u_input_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in_fire_c),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (in_data),
        .x_buf_o   (x_buf)
    );

    // Next-state, counter and result-capture logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        sel_d        = sel_q;
        settle_cnt_d = settle_cnt_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_fire_c) begin
                    if (wr_ptr_q == PW'(IN - 1)) begin
                        state_d      = ST_SETTLE;
                        wr_ptr_d     = '0;
                        sel_d        = '0;
                        settle_cnt_d = '0;
                    end else begin
                        state_d  = ST_LOAD;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == CW'(SETTLE_CYC - 1)) begin
                    out_data_d = z_in;
                    out_idx_d  = sel_q;
                    out_last_d = (sel_q == SW'(N_OUT - 1));
                    state_d    = ST_EMIT;
                end else begin
                    settle_cnt_d = settle_cnt_q + CW'(1);
                end
            end
            ST_EMIT: begin
                if (out_fire_c) begin
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
                    end else begin
                        state_d      = ST_SETTLE;
                        sel_d        = sel_q + SW'(1);
                        settle_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counters and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            sel_q        <= '0;
            settle_cnt_q <= '0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            sel_q        <= sel_d;
            settle_cnt_q <= settle_cnt_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

`ifdef FC_ARGMAX_EN
    logic signed [ZW-1:0] max_q, max_d;
    logic [SW-1:0]        run_idx_q, run_idx_d;
    logic [SW-1:0]        amax_idx_q, amax_idx_d;
    logic                 amax_vld_q, amax_vld_d;
    logic                 capture_c;
    logic                 last_fire_c;

    assign capture_c   = (state_q == ST_SETTLE) && (settle_cnt_q == CW'(SETTLE_CYC - 1));
    assign last_fire_c = out_fire_c && out_last_q && (state_q == ST_EMIT);

    // Running signed max over captured results; strict compare keeps the lower index on ties
    always_comb begin
        max_d      = max_q;
        run_idx_d  = run_idx_q;
        amax_idx_d = amax_idx_q;
        amax_vld_d = 1'b0;
        if (capture_c) begin
            if ((sel_q == '0) || ($signed(z_in) > max_q)) begin
                max_d     = $signed(z_in);
                run_idx_d = sel_q;
            end
        end
        if (last_fire_c) begin
            amax_vld_d = 1'b1;
            amax_idx_d = run_idx_q;
        end
    end

    // Argmax registers; result index held until the next vector completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q      <= '0;
            run_idx_q  <= '0;
            amax_idx_q <= '0;
            amax_vld_q <= 1'b0;
        end else begin
            max_q      <= max_d;
            run_idx_q  <= run_idx_d;
            amax_idx_q <= amax_idx_d;
            amax_vld_q <= amax_vld_d;
        end
    end

    assign argmax_valid = amax_vld_q;
    assign argmax_idx   = amax_idx_q;
`endif

endmodule
